// File: rtl/sseg_display_arbiter_if.sv
// Request/data bundle between the three display requesters and the arbiter,
// plus the registered display outputs that feed the SSEG multiplexing driver.
interface sseg_display_arbiter_if;
    logic [2:0]  req;
    logic [15:0] data0;
    logic [15:0] data1;
    logic [15:0] data2;
    logic [3:0]  dp0;
    logic [3:0]  dp1;
    logic [3:0]  dp2;
    logic [15:0] data;
    logic [3:0]  dp_out;
    logic [2:0]  grant;
    logic        switched;

    modport master (
        output req, data0, data1, data2, dp0, dp1, dp2,
        input  data, dp_out, grant, switched
    );

    modport slave (
        input  req, data0, data1, data2, dp0, dp1, dp2,
        output data, dp_out, grant, switched
    );
endinterface

// File: rtl/sseg_display_arbiter.sv
// Shares the 4-digit display between alarm (pre-emptive), game status and
// timer with a minimum dwell per grant and round-robin among normal sources.
module sseg_display_arbiter #(
    parameter int unsigned HOLD_CYCLES = 25_000_000,
    parameter logic [15:0] IDLE_DATA   = 16'h0000
) (
    input  logic                         clk_50M,
    input  logic                         reset,
    sseg_display_arbiter_if.slave        bus
);
    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        OPEN = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       ptr, ptr_n;
    logic [2:0]       grant_q, grant_n;
    logic [15:0]      data_q, data_n;
    logic [3:0]       dp_q, dp_n;
    logic             switched_q, switched_n;
    logic             grant_hit;
    logic [1:0]       pick;
    logic [2:0]       others;

    // First set bit of mask searching upward from last+1 with wrap; last is checked last.
    function automatic logic [1:0] rr_pick(input logic [2:0] mask, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] sel;
        sel = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            idx = 2'((int'(last) + k) % 3);
            if (mask[idx]) sel = idx;
        end
        return sel;
    endfunction

    assign others = bus.req & ~grant_q;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        ptr_n      = ptr;
        grant_n    = grant_q;
        data_n     = data_q;
        dp_n       = dp_q;
        grant_hit  = 1'b0;
        pick       = ptr;

        unique case (state)
            IDLE: begin
                if (|bus.req) begin
                    grant_hit = 1'b1;
                    pick      = bus.req[0] ? 2'd0 : rr_pick(bus.req, ptr);
                end
            end
            HOLD, OPEN: begin
                if (bus.req[0] && (ptr != 2'd0)) begin
                    grant_hit = 1'b1;
                    pick      = 2'd0;
                end else if (state == HOLD) begin
                    if (cnt == CNT_W'(HOLD_CYCLES - 1)) state_n = OPEN;
                    else                                 cnt_n   = cnt + CNT_W'(1);
                end else if (|others) begin
                    grant_hit = 1'b1;
                    pick      = rr_pick(others, ptr);
                end else if (!bus.req[ptr]) begin
                    state_n = IDLE;
                    grant_n = 3'b000;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = 3'b000;
            end
        endcase

        if (grant_hit) begin
            state_n = HOLD;
            cnt_n   = '0;
            ptr_n   = pick;
            grant_n = 3'b001 << pick;
        end

        // Follow the owner's source while it requests; otherwise freeze, or blank when idle.
        if (grant_n == 3'b000) begin
            data_n = IDLE_DATA;
            dp_n   = 4'b0000;
        end else if (|(bus.req & grant_n)) begin
            unique case (ptr_n)
                2'd0:    begin data_n = bus.data0; dp_n = bus.dp0; end
                2'd1:    begin data_n = bus.data1; dp_n = bus.dp1; end
                default: begin data_n = bus.data2; dp_n = bus.dp2; end
            endcase
        end

        switched_n = (grant_n != grant_q);
    end

    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            ptr        <= 2'd2;
            grant_q    <= 3'b000;
            data_q     <= IDLE_DATA;
            dp_q       <= 4'b0000;
            switched_q <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ptr        <= ptr_n;
            grant_q    <= grant_n;
            data_q     <= data_n;
            dp_q       <= dp_n;
            switched_q <= switched_n;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.data     = data_q;
    assign bus.dp_out   = dp_q;
    assign bus.switched = switched_q;
endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Self-checking bench for sseg_display_arbiter: directed vector table, corner
// sequences, and randomized traffic against a behavioural arbitration model.
module tb_sseg_display_arbiter;
    localparam int unsigned HOLD = 8;
    localparam logic [15:0] IDLE_D = 16'h0000;

    logic clk_50M;
    logic reset;
    sseg_display_arbiter_if bus ();

    sseg_display_arbiter #(.HOLD_CYCLES(HOLD), .IDLE_DATA(IDLE_D)) dut (
        .clk_50M (clk_50M),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk_50M = 1'b0;
    always #5 clk_50M = ~clk_50M;

    int n_checks = 0;
    int n_errors = 0;

    // Model: owner index (-1 = nobody), edges elapsed since the grant, last granted index.
    int          m_owner;
    int          m_age;
    int          m_last;
    logic [15:0] m_data;
    logic [3:0]  m_dp;
    logic        m_sw;

    typedef struct {
        logic [2:0]  req;
        logic [15:0] d1;
        logic [3:0]  dp1;
        logic [2:0]  g;
        logic [15:0] dat;
        logic [3:0]  dp;
        logic        sw;
    } vec_t;
    vec_t vt[15];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int next_active(input logic [2:0] mask, input int start);
        for (int k = 1; k <= 3; k++) begin
            if (mask[(start + k) % 3]) return (start + k) % 3;
        end
        return -1;
    endfunction

    function automatic logic [2:0] m_grant();
        return (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_last  = 2;
        m_data  = IDLE_D;
        m_dp    = 4'b0000;
        m_sw    = 1'b0;
    endtask

    task automatic model_step();
        logic [2:0]  r;
        logic [2:0]  oth;
        logic [15:0] d[3];
        logic [3:0]  p[3];
        int          nxt;
        r = bus.req;
        d[0] = bus.data0; d[1] = bus.data1; d[2] = bus.data2;
        p[0] = bus.dp0;   p[1] = bus.dp1;   p[2] = bus.dp2;
        nxt = m_owner;
        if (m_owner < 0) begin
            if (r != 3'b000) nxt = r[0] ? 0 : next_active(r, m_last);
        end else if (r[0] && m_owner != 0) begin
            nxt = 0;
        end else if (m_age >= int'(HOLD)) begin
            oth = r;
            oth[m_owner] = 1'b0;
            if (oth != 3'b000)     nxt = next_active(oth, m_owner);
            else if (!r[m_owner])  nxt = -1;
        end
        m_sw = (nxt != m_owner);
        if (m_sw) m_age = 0;
        else if (m_age < int'(HOLD)) m_age++;
        if (m_sw && nxt >= 0) m_last = nxt;
        if (nxt < 0) begin
            m_data = IDLE_D;
            m_dp   = 4'b0000;
        end else if (r[nxt]) begin
            m_data = d[nxt];
            m_dp   = p[nxt];
        end
        m_owner = nxt;
    endtask

    // One clock: advance the model on the pre-edge inputs, then compare after the edge.
    task automatic cyc();
        model_step();
        @(posedge clk_50M);
        #1;
        check("grant",    16'(bus.grant),    16'(m_grant()));
        check("data",     bus.data,          m_data);
        check("dp_out",   16'(bus.dp_out),   16'(m_dp));
        check("switched", 16'(bus.switched), 16'(m_sw));
    endtask

    task automatic clear_inputs();
        bus.req = 3'b000;
        bus.data0 = 16'h0000; bus.data1 = 16'h0000; bus.data2 = 16'h0000;
        bus.dp0 = 4'h0; bus.dp1 = 4'h0; bus.dp2 = 4'h0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        @(posedge clk_50M);
        @(posedge clk_50M);
        #1;
        check("rst_grant",    16'(bus.grant),    16'h0000);
        check("rst_data",     bus.data,          IDLE_D);
        check("rst_dp",       16'(bus.dp_out),   16'h0000);
        check("rst_switched", 16'(bus.switched), 16'h0000);
        @(negedge clk_50M);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        // Single request, drop, fall back to idle, then live tracking of owner 1.
        vt[0] = '{3'b010, 16'h1234, 4'h0, 3'b010, 16'h1234, 4'h0, 1'b1};
        for (int i = 1; i <= 8; i++)
            vt[i] = '{3'b000, 16'h1234, 4'h0, 3'b010, 16'h1234, 4'h0, 1'b0};
        vt[9]  = '{3'b000, 16'h1234, 4'h0, 3'b000, 16'h0000, 4'h0, 1'b1};
        vt[10] = '{3'b000, 16'h1234, 4'h0, 3'b000, 16'h0000, 4'h0, 1'b0};
        vt[11] = '{3'b010, 16'h0001, 4'h0, 3'b010, 16'h0001, 4'h0, 1'b1};
        vt[12] = '{3'b010, 16'h0002, 4'h4, 3'b010, 16'h0002, 4'h4, 1'b0};
        vt[13] = '{3'b010, 16'h0003, 4'h4, 3'b010, 16'h0003, 4'h4, 1'b0};
        vt[14] = '{3'b000, 16'h0004, 4'h1, 3'b010, 16'h0003, 4'h4, 1'b0};

        model_reset();
        do_reset();

        for (int i = 0; i < 15; i++) begin
            bus.req = vt[i].req;
            bus.data1 = vt[i].d1;
            bus.dp1 = vt[i].dp1;
            cyc();
            check($sformatf("vec%0d_grant", i), 16'(bus.grant), 16'(vt[i].g));
            check($sformatf("vec%0d_data", i),  bus.data,       vt[i].dat);
            check($sformatf("vec%0d_dp", i),    16'(bus.dp_out), 16'(vt[i].dp));
            check($sformatf("vec%0d_sw", i),    16'(bus.switched), 16'(vt[i].sw));
        end

        // Round-robin between sources 1 and 2 with constant requests.
        do_reset();
        bus.req = 3'b110;
        cyc();
        check("rr_first", 16'(bus.grant), 16'h0002);
        for (int i = 0; i < 8; i++) cyc();
        check("rr_hold1", 16'(bus.grant), 16'h0002);
        cyc();
        check("rr_second", 16'(bus.grant), 16'h0004);
        check("rr_sw2", 16'(bus.switched), 16'h0001);
        for (int i = 0; i < 9; i++) cyc();
        check("rr_third", 16'(bus.grant), 16'h0002);

        // Alarm pre-empts source 2 at dwell cycle 3 and restarts the dwell.
        do_reset();
        bus.req = 3'b100; bus.data2 = 16'h2222;
        cyc();
        for (int i = 0; i < 3; i++) cyc();
        bus.req = 3'b101; bus.data0 = 16'hA1A1; bus.dp0 = 4'h8;
        cyc();
        check("pre_grant", 16'(bus.grant), 16'h0001);
        check("pre_data",  bus.data,       16'hA1A1);
        check("pre_sw",    16'(bus.switched), 16'h0001);
        for (int i = 0; i < 8; i++) cyc();
        check("pre_dwell", 16'(bus.grant), 16'h0001);
        cyc();
        check("pre_handback", 16'(bus.grant), 16'h0004);

        // A normal source raised mid-dwell must wait for the dwell to expire.
        do_reset();
        bus.req = 3'b100;
        cyc();
        for (int i = 0; i < 3; i++) cyc();
        bus.req = 3'b110;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("nopre_hold", 16'(bus.grant), 16'h0004);
        end
        cyc();
        check("nopre_switch", 16'(bus.grant), 16'h0002);

        // Simultaneous requests from idle: alarm first, then the normal sources alternate.
        do_reset();
        bus.req = 3'b111;
        cyc();
        check("sim_first", 16'(bus.grant), 16'h0001);
        bus.req = 3'b110;
        for (int i = 0; i < 8; i++) cyc();
        check("sim_hold", 16'(bus.grant), 16'h0001);
        cyc();
        check("sim_second", 16'(bus.grant), 16'h0002);
        for (int i = 0; i < 9; i++) cyc();
        check("sim_third", 16'(bus.grant), 16'h0004);
        for (int i = 0; i < 20; i++) begin
            cyc();
            check("sim_no_alarm", 16'(bus.grant[0]), 16'h0000);
        end

        // Asynchronous reset mid-dwell, then a full dwell after release.
        do_reset();
        bus.req = 3'b100; bus.data2 = 16'h5A5A; bus.dp2 = 4'hF;
        cyc();
        for (int i = 0; i < 5; i++) cyc();
        #2;
        reset = 1'b0;
        #1;
        check("arst_grant",    16'(bus.grant),    16'h0000);
        check("arst_data",     bus.data,          16'h0000);
        check("arst_dp",       16'(bus.dp_out),   16'h0000);
        check("arst_switched", 16'(bus.switched), 16'h0000);
        model_reset();
        @(negedge clk_50M);
        reset = 1'b1;
        cyc();
        check("arst_regrant", 16'(bus.grant), 16'h0004);
        bus.req = 3'b110;
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("arst_dwell", 16'(bus.grant), 16'h0004);
        end
        cyc();
        check("arst_after", 16'(bus.grant), 16'h0002);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) bus.req[1] = ~bus.req[1];
            if ($urandom_range(0, 5) == 0) bus.req[2] = ~bus.req[2];
            bus.req[0] = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 2) == 0) begin
                bus.data0 = 16'($urandom); bus.data1 = 16'($urandom); bus.data2 = 16'($urandom);
                bus.dp0 = 4'($urandom);    bus.dp1 = 4'($urandom);    bus.dp2 = 4'($urandom);
            end
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
